// File: rtl/ghost_ram_loader.sv
// Ghost sprite RAM write-side feeder: unpacks 32-bit MMIO words into one pixel write per clock.
// Optional build macro SKIP_TRANSPARENT_EN suppresses writes of TRANSPARENT_COLOR pixels.
module ghost_ram_loader #(
  parameter int ADDR_WIDTH        = 13,
  parameter int DATA_WIDTH        = 3,
  parameter int TRANSPARENT_COLOR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_op,
  input  logic [31:0]           s_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  word_done
);

  localparam int PIX_PER_WORD = 32 / DATA_WIDTH;
  localparam int CNT_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [DATA_WIDTH-1:0] KEY_COLOR = DATA_WIDTH'(TRANSPARENT_COLOR);
`ifdef SKIP_TRANSPARENT_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE   = 1'b0,
    UNPACK = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic                  word_done_q, word_done_d;
  logic                  last_pix;
  logic                  key_hit;
  logic                  skip_px;

  assign last_pix = (cnt_q == CNT_W'(PIX_PER_WORD - 1));
  assign key_hit  = (shift_q[DATA_WIDTH-1:0] == KEY_COLOR);
  assign skip_px  = key_hit & SKIP_EN;

  // Write port is decoded from registered state only; no path from s_* inputs.
  assign s_ready    = (state_q == IDLE);
  assign busy       = (state_q == UNPACK);
  assign ram_we     = (state_q == UNPACK) && !skip_px;
  assign ram_addr_w = wr_addr_q;
  assign ram_din    = shift_q[DATA_WIDTH-1:0];
  assign wr_addr    = wr_addr_q;
  assign word_done  = word_done_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    word_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          if (s_op) begin
            wr_addr_d = s_data[ADDR_WIDTH-1:0];
          end else begin
            shift_d = s_data;
            cnt_d   = '0;
            state_d = UNPACK;
          end
        end
      end
      UNPACK: begin
        // Address advances even for skipped pixels and wraps silently.
        shift_d   = shift_q >> DATA_WIDTH;
        wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_pix) begin
          state_d     = IDLE;
          word_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      wr_addr_q   <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      wr_addr_q   <= wr_addr_d;
      word_done_q <= word_done_d;
    end
  end

endmodule
